// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-back/write-allocate data cache, one 64-bit doubleword per line.
// state       | meaning
// IDLE        | ready for a CPU request
// LOOKUP      | tag compare; store hits merge here
// WB          | issue dirty victim write-back
// WB_WAIT     | wait for write ack
// REFILL      | issue line read
// REFILL_WAIT | wait for refill data, install line
// RESP        | one-cycle response pulse
module dcache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [63:0]       mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_rdata
);

  localparam int TAG_W = ADDR_W - INDEX_W - 3;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, WB_WAIT, REFILL, REFILL_WAIT, RESP
  } state_t;

  state_t state, state_nxt;

  logic              r_we;
  logic [ADDR_W-4:0] r_line;
  logic [63:0]       r_wdata;
  logic [7:0]        r_wstrb;

  logic [LINES-1:0]  valid, dirty;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [63:0]       data_arr [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   r_tag;
  logic               hit, fill, line_wr, resp_load;
  logic [63:0]        base, line_data;
  logic               addr_unused;

  assign addr_unused = ^req_addr[2:0];
  assign idx   = r_line[INDEX_W-1:0];
  assign r_tag = r_line[ADDR_W-4:INDEX_W];
  assign hit   = valid[idx] && (tag_arr[idx] == r_tag);

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] st);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++)
      if (st[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit)                          state_nxt = RESP;
        else if (valid[idx] && dirty[idx]) state_nxt = WB;
        else                              state_nxt = REFILL;
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {tag_arr[idx], idx, 3'b000};
        mem_req_wdata = data_arr[idx];
        if (mem_req_ready) state_nxt = WB_WAIT;
      end
      WB_WAIT:     if (mem_resp_valid) state_nxt = REFILL;
      REFILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_tag, idx, 3'b000};
        if (mem_req_ready) state_nxt = REFILL_WAIT;
      end
      REFILL_WAIT: if (mem_resp_valid) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default:     state_nxt = IDLE;
    endcase
  end

  // Store hits merge into the cached word; refills merge into the fetched word.
  always_comb begin
    fill      = (state == REFILL_WAIT) && mem_resp_valid;
    base      = (state == LOOKUP) ? data_arr[idx] : mem_resp_rdata;
    line_data = r_we ? merge(base, r_wdata, r_wstrb) : base;
    line_wr   = ((state == LOOKUP) && hit && r_we) || fill;
    resp_load = ((state == LOOKUP) && hit) || fill;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= '0;
      dirty      <= '0;
      resp_rdata <= '0;
      r_we       <= 1'b0;
      r_line     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_line  <= req_addr[ADDR_W-1:3];
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
      end
      if (resp_load) resp_rdata <= line_data;
      if (state == LOOKUP && hit && r_we) dirty[idx] <= 1'b1;
      if (state == WB_WAIT && mem_resp_valid) dirty[idx] <= 1'b0;
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= r_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (line_wr) data_arr[idx] <= line_data;
    if (fill)    tag_arr[idx]  <= r_tag;
  end

endmodule
